// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the fetch / load-store memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    SZ_B   = 2'd0,
    SZ_H   = 2'd1,
    SZ_W   = 2'd2,
    SZ_BAD = 2'd3
  } size_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  function automatic logic [3:0] size_to_mask(size_e size);
    logic [3:0] mask;
    case (size)
      SZ_B:    mask = 4'b0001;
      SZ_H:    mask = 4'b0011;
      SZ_W:    mask = 4'b1111;
      default: mask = 4'b0000;
    endcase
    return mask;
  endfunction

  function automatic logic [2:0] size_bytes(size_e size);
    logic [2:0] bytes;
    case (size)
      SZ_B:    bytes = 3'd1;
      SZ_H:    bytes = 3'd2;
      SZ_W:    bytes = 3'd4;
      default: bytes = 3'd0;
    endcase
    return bytes;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_load_formatter.sv
// Sign/zero extension of the lane-0-justified memory word for byte and half loads.
module load_formatter
  import mem_arb_pkg::*;
(
  input  logic [31:0] raw_i,
  input  size_e       size_i,
  input  logic        unsigned_i,
  output logic [31:0] data_o
);

  logic signBit;

  always_comb begin
    data_o  = raw_i;
    signBit = 1'b0;
    case (size_i)
      SZ_B: begin
        signBit = raw_i[7] & ~unsigned_i;
        data_o  = {{24{signBit}}, raw_i[7:0]};
      end
      SZ_H: begin
        signBit = raw_i[15] & ~unsigned_i;
        data_o  = {{16{signBit}}, raw_i[15:0]};
      end
      default: data_o = raw_i;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and load/store accesses onto one byte-striped memory port
// and returns the registered, extended response one cycle after grant.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 15,
  parameter int ARB_MODE   = ARB_RR
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  if_req_i,
  input  logic [ADDR_WIDTH-1:0] if_addr_i,
  output logic                  if_gnt_o,
  output logic                  if_rvalid_o,
  output logic [31:0]           if_rdata_o,
  input  logic                  d_req_i,
  input  logic                  d_we_i,
  input  logic [1:0]            d_size_i,
  input  logic                  d_unsigned_i,
  input  logic [ADDR_WIDTH-1:0] d_addr_i,
  input  logic [31:0]           d_wdata_i,
  output logic                  d_gnt_o,
  output logic                  d_rvalid_o,
  output logic                  d_err_o,
  output logic [31:0]           d_rdata_o,
  output logic [3:0]            mem_write_mask_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [31:0]           mem_write_data_o,
  input  logic [31:0]           mem_read_data_i
);

  logic                  ifReq, dReq, ifWin, dWin, dErr;
  size_e                 dSize;
  logic [ADDR_WIDTH:0]   dEnd;
  owner_e                rrPtr_q, rrPtr_d;
  logic [ADDR_WIDTH-1:0] memAddr_q, memAddr_d;
  logic                  rvalid_q, rvalid_d;
  owner_e                owner_q, owner_d;
  size_e                 size_q, size_d;
  logic                  unsigned_q, unsigned_d;
  logic                  we_q, we_d;
  logic                  err_q, err_d;
  logic                  respValid;
  logic [31:0]           loadData;

  // Requests are masked during reset so nothing is granted while rst_i is high.
  always_comb begin
    ifReq   = if_req_i & ~rst_i;
    dReq    = d_req_i & ~rst_i;
    dSize   = size_e'(d_size_i);
    dEnd    = {1'b0, d_addr_i} + (ADDR_WIDTH + 1)'(size_bytes(dSize))
              - (ADDR_WIDTH + 1)'(1);
    dErr    = (dSize == SZ_BAD) | dEnd[ADDR_WIDTH];
    if (ARB_MODE == ARB_FIXED) begin
      dWin = dReq;
    end else begin
      dWin = dReq & (~ifReq | (rrPtr_q == OWN_D));
    end
    ifWin   = ifReq & ~dWin;
    rrPtr_d = rrPtr_q;
    if ((ARB_MODE == ARB_RR) && ifReq && dReq) begin
      rrPtr_d = dWin ? OWN_IF : OWN_D;
    end
  end

  always_comb begin
    memAddr_d        = memAddr_q;
    mem_write_mask_o = 4'b0000;
    mem_write_data_o = 32'h0;
    if (dWin) begin
      memAddr_d = d_addr_i;
      if (d_we_i && !dErr) begin
        mem_write_mask_o = size_to_mask(dSize);
        mem_write_data_o = d_wdata_i;
      end
    end else if (ifWin) begin
      memAddr_d = if_addr_i;
    end
    rvalid_d   = ifWin | dWin;
    owner_d    = dWin ? OWN_D : OWN_IF;
    size_d     = dSize;
    unsigned_d = d_unsigned_i;
    we_d       = d_we_i;
    err_d      = dWin & dErr;
  end

  assign if_gnt_o   = ifWin;
  assign d_gnt_o    = dWin;
  assign mem_addr_o = memAddr_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rrPtr_q    <= OWN_IF;
      memAddr_q  <= '0;
      rvalid_q   <= 1'b0;
      owner_q    <= OWN_IF;
      size_q     <= SZ_B;
      unsigned_q <= 1'b0;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      rrPtr_q    <= rrPtr_d;
      memAddr_q  <= memAddr_d;
      rvalid_q   <= rvalid_d;
      owner_q    <= owner_d;
      size_q     <= size_d;
      unsigned_q <= unsigned_d;
      we_q       <= we_d;
      err_q      <= err_d;
    end
  end

  load_formatter u_fmt (
    .raw_i      (mem_read_data_i),
    .size_i     (size_q),
    .unsigned_i (unsigned_q),
    .data_o     (loadData)
  );

  // A response still in flight when reset arrives is suppressed immediately.
  always_comb begin
    respValid   = rvalid_q & ~rst_i;
    if_rvalid_o = respValid & (owner_q == OWN_IF);
    d_rvalid_o  = respValid & (owner_q == OWN_D);
    d_err_o     = d_rvalid_o & err_q;
    if_rdata_o  = if_rvalid_o ? mem_read_data_i : 32'h0;
    d_rdata_o   = (d_rvalid_o && !we_q && !err_q) ? loadData : 32'h0;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: byte-striped memory model plus a response scoreboard.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifReq, dReq, dWe, dUns;
  logic [14:0] ifAddr, dAddr;
  logic [1:0]  dSize;
  logic [31:0] dWdata;
  logic        ifGnt, ifRvalid, dGnt, dRvalid, dErr;
  logic [31:0] ifRdata, dRdata, memWdata, memRdata;
  logic [3:0]  memMask;
  logic [14:0] memAddr;

  logic        fIfReq, fDReq;
  logic        fIfGnt, fIfRvalid, fDGnt, fDRvalid, fDErr;
  logic [31:0] fIfRdata, fDRdata, fMemWdata;
  logic [3:0]  fMemMask;
  logic [14:0] fMemAddr;

  int errCount = 0;
  int checkCount = 0;

  typedef struct packed {
    logic        isData;
    logic        err;
    logic [31:0] data;
  } exp_t;
  exp_t sbQ[$];

  logic [7:0] mem [0:32767];
  logic       memInitDone = 1'b0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_WIDTH(15), .ARB_MODE(0)) dut (
    .clk_i(clk), .rst_i(rst),
    .if_req_i(ifReq), .if_addr_i(ifAddr), .if_gnt_o(ifGnt),
    .if_rvalid_o(ifRvalid), .if_rdata_o(ifRdata),
    .d_req_i(dReq), .d_we_i(dWe), .d_size_i(dSize), .d_unsigned_i(dUns),
    .d_addr_i(dAddr), .d_wdata_i(dWdata), .d_gnt_o(dGnt),
    .d_rvalid_o(dRvalid), .d_err_o(dErr), .d_rdata_o(dRdata),
    .mem_write_mask_o(memMask), .mem_addr_o(memAddr),
    .mem_write_data_o(memWdata), .mem_read_data_i(memRdata)
  );

  mem_port_arbiter #(.ADDR_WIDTH(15), .ARB_MODE(1)) u_fix (
    .clk_i(clk), .rst_i(rst),
    .if_req_i(fIfReq), .if_addr_i(15'h0040), .if_gnt_o(fIfGnt),
    .if_rvalid_o(fIfRvalid), .if_rdata_o(fIfRdata),
    .d_req_i(fDReq), .d_we_i(1'b0), .d_size_i(2'd2), .d_unsigned_i(1'b0),
    .d_addr_i(15'h0080), .d_wdata_i(32'h0), .d_gnt_o(fDGnt),
    .d_rvalid_o(fDRvalid), .d_err_o(fDErr), .d_rdata_o(fDRdata),
    .mem_write_mask_o(fMemMask), .mem_addr_o(fMemAddr),
    .mem_write_data_o(fMemWdata), .mem_read_data_i(32'h0)
  );

  function automatic logic [31:0] modelWord(input logic [14:0] a);
    return {mem[a + 15'd3], mem[a + 15'd2], mem[a + 15'd1], mem[a]};
  endfunction

  // Memory model: lane i of the word lives at byte address addr+i.
  always @(posedge clk) begin
    if (!memInitDone) begin
      for (int i = 0; i < 32768; i++) mem[i] <= 8'(i) ^ 8'h5A;
      memInitDone <= 1'b1;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (memMask[i]) mem[memAddr + 15'(i)] <= memWdata[8*i +: 8];
      end
    end
    memRdata <= modelWord(memAddr);
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  function automatic exp_t expectData();
    exp_t e;
    int   nb;
    logic [31:0] w;
    nb = (dSize == 2'd0) ? 1 : (dSize == 2'd1) ? 2 : 4;
    e.isData = 1'b1;
    e.err    = (dSize == 2'd3) || (int'(dAddr) + nb - 1 > 32767);
    e.data   = 32'h0;
    if (!e.err && !dWe) begin
      w = modelWord(dAddr);
      if (dSize == 2'd0)      e.data = dUns ? {24'h0, w[7:0]}  : 32'($signed(w[7:0]));
      else if (dSize == 2'd1) e.data = dUns ? {16'h0, w[15:0]} : 32'($signed(w[15:0]));
      else                    e.data = w;
    end
    return e;
  endfunction

  // Scoreboard: pop on each response, push on each grant; reset drops everything.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sbQ.delete();
    end else begin
      if (ifRvalid || dRvalid) begin
        if (sbQ.size() == 0) begin
          checkOutput("sbUnexpected", 32'd1, 32'd0);
        end else begin
          e = sbQ.pop_front();
          checkOutput("sbPort", 32'(dRvalid), 32'(e.isData));
          checkOutput("sbErr", 32'(dErr), 32'(e.err));
          checkOutput("sbData", dRvalid ? dRdata : ifRdata, e.data);
        end
      end
      if (ifGnt) sbQ.push_back('{1'b0, 1'b0, modelWord(ifAddr)});
      if (dGnt)  sbQ.push_back(expectData());
    end
  end

  task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                               input logic [14:0] addr, input logic [31:0] wdata,
                               output logic [31:0] rdata, output logic err,
                               output logic [3:0] mask);
    bit granted = 0;
    rdata = 32'h0; err = 1'b0; mask = 4'h0;
    @(posedge clk); #1;
    dReq = 1'b1; dWe = we; dSize = size; dUns = uns; dAddr = addr; dWdata = wdata;
    for (int c = 0; c < 20 && !granted; c++) begin
      @(negedge clk);
      if (dGnt) begin
        granted = 1;
        mask = memMask;
      end
    end
    if (!granted) begin
      checkOutput("dGntTimeout", 32'd0, 32'd1);
      dReq = 1'b0;
      return;
    end
    @(posedge clk); #1;
    dReq = 1'b0;
    @(negedge clk);
    checkOutput("dRvalid", 32'(dRvalid), 32'd1);
    checkOutput("addrHold", 32'(memAddr), 32'(addr));
    checkOutput("idleMask", 32'(memMask), 32'd0);
    rdata = dRdata;
    err = dErr;
  endtask

  task automatic applyFetchStimulus(input logic [14:0] addr, output logic [31:0] rdata);
    bit granted = 0;
    rdata = 32'h0;
    @(posedge clk); #1;
    ifReq = 1'b1; ifAddr = addr;
    for (int c = 0; c < 20 && !granted; c++) begin
      @(negedge clk);
      if (ifGnt) begin
        granted = 1;
        checkOutput("fetchMask", 32'(memMask), 32'd0);
      end
    end
    if (!granted) begin
      checkOutput("ifGntTimeout", 32'd0, 32'd1);
      ifReq = 1'b0;
      return;
    end
    @(posedge clk); #1;
    ifReq = 1'b0;
    @(negedge clk);
    checkOutput("ifRvalid", 32'(ifRvalid), 32'd1);
    rdata = ifRdata;
  endtask

  initial begin
    logic [31:0] r;
    logic        e;
    logic [3:0]  m;
    rst = 1'b1;
    ifReq = 1'b0; ifAddr = '0;
    dReq = 1'b0; dWe = 1'b0; dSize = 2'd2; dUns = 1'b0; dAddr = '0; dWdata = '0;
    fIfReq = 1'b0; fDReq = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("rstGnt", {30'h0, ifGnt, dGnt}, 32'd0);
    checkOutput("rstRvalid", {29'h0, ifRvalid, dRvalid, dErr}, 32'd0);
    checkOutput("rstMask", 32'(memMask), 32'd0);
    checkOutput("rstAddr", 32'(memAddr), 32'd0);

    // Reset mid-load: the granted load never responds.
    @(posedge clk); #1;
    dReq = 1'b1; dWe = 1'b0; dSize = 2'd2; dAddr = 15'h1234;
    @(negedge clk);
    checkOutput("rstLoadGnt", 32'(dGnt), 32'd1);
    @(posedge clk); #1;
    dReq = 1'b0; rst = 1'b1;
    @(negedge clk);
    checkOutput("rstLoadRvalid", 32'(dRvalid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("postRstRvalid", {30'h0, ifRvalid, dRvalid}, 32'd0);
    checkOutput("postRstErr", 32'(dErr), 32'd0);
    checkOutput("postRstRdata", dRdata | ifRdata, 32'd0);
    checkOutput("postRstMask", 32'(memMask), 32'd0);
    checkOutput("postRstAddr", 32'(memAddr), 32'd0);
    checkOutput("postRstWdata", memWdata, 32'd0);

    // Round-robin contention: if, d, if, d with responses one cycle behind.
    @(posedge clk); #1;
    ifReq = 1'b1; ifAddr = 15'h0020;
    dReq = 1'b1; dWe = 1'b0; dSize = 2'd2; dUns = 1'b0; dAddr = 15'h0010;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput("rrIfGnt", 32'(ifGnt), 32'(k % 2 == 0));
      checkOutput("rrDGnt", 32'(dGnt), 32'(k % 2 == 1));
      if (k > 0) checkOutput("rrIfRvalid", 32'(ifRvalid), 32'((k - 1) % 2 == 0));
      @(posedge clk); #1;
    end
    ifReq = 1'b0; dReq = 1'b0;
    @(negedge clk);
    checkOutput("rrLastRvalid", 32'(dRvalid), 32'd1);

    applyFetchStimulus(15'h0200, r);
    checkOutput("fetchData", r, 32'h59585B5A);

    applyStimulus(1'b1, 2'd0, 1'b0, 15'h0003, 32'h000000A5, r, e, m);
    checkOutput("sbMask", 32'(m), 32'h1);
    checkOutput("sbAck", r, 32'h0);
    applyStimulus(1'b0, 2'd0, 1'b0, 15'h0003, 32'h0, r, e, m);
    checkOutput("lbData", r, 32'hFFFFFFA5);
    checkOutput("lbMask", 32'(m), 32'h0);
    applyStimulus(1'b0, 2'd0, 1'b1, 15'h0003, 32'h0, r, e, m);
    checkOutput("lbuData", r, 32'h000000A5);

    applyStimulus(1'b1, 2'd2, 1'b0, 15'h0101, 32'h11223344, r, e, m);
    checkOutput("swMask", 32'(m), 32'hF);
    applyStimulus(1'b0, 2'd1, 1'b0, 15'h0102, 32'h0, r, e, m);
    checkOutput("lhData", r, 32'h00002233);
    applyStimulus(1'b0, 2'd2, 1'b0, 15'h0101, 32'h0, r, e, m);
    checkOutput("lwUnaligned", r, 32'h11223344);

    applyStimulus(1'b0, 2'd2, 1'b0, 15'h7FFD, 32'h0, r, e, m);
    checkOutput("errTopErr", 32'(e), 32'd1);
    checkOutput("errTopData", r, 32'h0);
    checkOutput("errTopMask", 32'(m), 32'h0);
    applyStimulus(1'b0, 2'd3, 1'b0, 15'h0000, 32'h0, r, e, m);
    checkOutput("errSizeErr", 32'(e), 32'd1);
    checkOutput("errSizeData", r, 32'h0);
    applyStimulus(1'b1, 2'd1, 1'b0, 15'h7FFF, 32'hBEEF, r, e, m);
    checkOutput("errStoreErr", 32'(e), 32'd1);
    checkOutput("errStoreMask", 32'(m), 32'h0);
    applyStimulus(1'b0, 2'd2, 1'b0, 15'h7FFC, 32'h0, r, e, m);
    checkOutput("lwTopErr", 32'(e), 32'd0);
    checkOutput("lwTopData", r, 32'hA5A4A7A6);

    // Fixed priority: data wins while both request.
    @(posedge clk); #1;
    fIfReq = 1'b1; fDReq = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("fixDGnt", 32'(fDGnt), 32'd1);
      checkOutput("fixIfGnt", 32'(fIfGnt), 32'd0);
      @(posedge clk); #1;
    end
    fDReq = 1'b0;
    @(negedge clk);
    checkOutput("fixIfAfter", 32'(fIfGnt), 32'd1);
    checkOutput("fixDRvalid", 32'(fDRvalid), 32'd1);
    @(posedge clk); #1;
    fIfReq = 1'b0;
    repeat (2) @(negedge clk);

    checkOutput("sbDrain", 32'(sbQ.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
